truth_table_sweeper: RTL

//  Self-checking exhaustive stimulus engine for combinational DUTs with up to N_IN inputs.

---
 rtl/truth_table_sweeper_if.sv | 36 +++
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - handshake/result bundle between sweeper and the combinational DUT
// Optional fail_map signal exists only when SWEEP_LOG_EN is defined.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic [N_IN-1:0]        stim;
  logic                   dut_f;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_cnt;
  logic                   first_fail_vld;
  logic [N_IN-1:0]        first_fail_idx;
`ifdef SWEEP_LOG_EN
  logic [(2**N_IN)-1:0]   fail_map;
`endif

  // Sweeper side: drives stimulus and results, receives start and the DUT output
  modport master (
`ifdef SWEEP_LOG_EN
    output fail_map,
`endif
    input  start, dut_f,
    output stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
  );

  // Environment side: issues start, returns DUT output, observes results
  modport slave (
`ifdef SWEEP_LOG_EN
    input  fail_map,
`endif
    output start, dut_f,
    input  stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and compare engine (optional SWEEP_LOG_EN fail map)
module truth_table_sweeper #(
  parameter int                     N_IN     = 4,
  parameter int                     SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]   EXPECTED = 16'h6996
) (
  input  logic                       clk,
  input  logic                       rst,
  truth_table_sweeper_if.master      bus
);

  localparam int              SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   RELOAD = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = {N_IN{1'b1}};

  // Parameter sanity is checked at elaboration so bad builds never reach hardware
  if (SETTLE < 1) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE must be >= 1");
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("truth_table_sweeper: N_IN must be within 1..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [N_IN-1:0]   stim_q;
  logic [SW-1:0]     settle_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_IN:0]     err_cnt_q;
  logic              ff_vld_q;
  logic [N_IN-1:0]   ff_idx_q;
`ifdef SWEEP_LOG_EN
  logic [(2**N_IN)-1:0] fail_map_q;
`endif

  logic              mismatch_d;
  logic [N_IN:0]     err_cnt_d;

  // Compare the live DUT output against the expected bit for the current vector
  always_comb begin
    mismatch_d = (bus.dut_f != EXPECTED[stim_q]);
    err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
  end

  // Sweep FSM; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stim_q     <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      ff_vld_q   <= 1'b0;
      ff_idx_q   <= '0;
`ifdef SWEEP_LOG_EN
      fail_map_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A start from either resting state launches a fresh sweep with cleared results
          if (bus.start) begin
            state_q    <= RUN;
            stim_q     <= '0;
            settle_q   <= RELOAD;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            ff_vld_q   <= 1'b0;
            ff_idx_q   <= '0;
`ifdef SWEEP_LOG_EN
            fail_map_q <= '0;
`endif
          end
        end
        RUN: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - 1'b1;
          end else begin
            err_cnt_q <= err_cnt_d;
            if (mismatch_d && !ff_vld_q) begin
              ff_vld_q <= 1'b1;
              ff_idx_q <= stim_q;
            end
`ifdef SWEEP_LOG_EN
            if (mismatch_d) begin
              fail_map_q[stim_q] <= 1'b1;
            end
`endif
            // Stop at all-ones rather than wrapping; the last compare is folded into pass
            if (stim_q != LAST) begin
              stim_q   <= stim_q + 1'b1;
              settle_q <= RELOAD;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.first_fail_vld = ff_vld_q;
  assign bus.first_fail_idx = ff_idx_q;
`ifdef SWEEP_LOG_EN
  assign bus.fail_map       = fail_map_q;
`endif

endmodule
